// File: rtl/pc_branch_ctrl_if.sv
// Control/status bundle between the instruction decoder, the ALU flag and pc_branch_ctrl.
// With BR_STATS_EN defined the bundle also carries the taken-branch counter br_cnt.
interface pc_branch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 5
);
    logic             start;
    logic             stall;
    logic             halt_req;
    logic             jmp_en;
    logic             br_en;
    logic             br_flag;
    logic [IDX_W-1:0] tgt_idx;
    logic             lut_we;
    logic [IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic [PC_W-1:0]  pc_out;
    logic             busy;
    logic             done;
    logic             taken;
`ifdef BR_STATS_EN
    logic [15:0]      br_cnt;
`endif

    modport master (
        output start, stall, halt_req, jmp_en, br_en, br_flag, tgt_idx,
        output lut_we, lut_waddr, lut_wdata,
`ifdef BR_STATS_EN
        input  br_cnt,
`endif
        input  pc_out, busy, done, taken
    );

    modport slave (
        input  start, stall, halt_req, jmp_en, br_en, br_flag, tgt_idx,
        input  lut_we, lut_waddr, lut_wdata,
`ifdef BR_STATS_EN
        output br_cnt,
`endif
        output pc_out, busy, done, taken
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// Program counter / branch resolution: IDLE-RUN-HALTED sequencer plus a writable table of
// signed PC offsets. Define BR_STATS_EN to add the saturating taken-branch counter br_cnt.
module pc_branch_ctrl #(
    parameter int PC_W       = 10,
    parameter int IDX_W      = 5,
    parameter int START_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_branch_ctrl_if.slave    bus
);
    localparam int              LUT_DEPTH = 1 << IDX_W;
    localparam logic [PC_W-1:0] START_PC  = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            taken_reg, taken_next;
    logic            start_load;
    logic            take_evt;

    logic [PC_W-1:0] lut_mem [0:LUT_DEPTH-1];
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_tgt;
    logic            branch_take;

    // Offset table: asynchronous read so a same-cycle write is only seen on the next cycle.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            lut_mem[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign offset      = lut_mem[bus.tgt_idx];
    assign pc_seq      = pc_reg + PC_W'(1);
    assign pc_tgt      = pc_reg + offset;
    assign branch_take = bus.jmp_en | (bus.br_en & bus.br_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= START_PC;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            taken_reg <= taken_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        taken_next = taken_reg;
        start_load = 1'b0;
        take_evt   = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_HALTED: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    pc_next    = START_PC;
                    taken_next = 1'b0;
                    start_load = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt outranks jump/branch; a stall freezes everything, including a pending halt.
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state_next = ST_HALTED;
                        taken_next = 1'b0;
                    end else if (branch_take) begin
                        pc_next    = pc_tgt;
                        taken_next = 1'b1;
                        take_evt   = 1'b1;
                    end else begin
                        pc_next    = pc_seq;
                        taken_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.pc_out = pc_reg;
    assign bus.busy   = (state_reg == ST_RUN);
    assign bus.done   = (state_reg == ST_HALTED);
    assign bus.taken  = taken_reg;

`ifdef BR_STATS_EN
    logic [15:0] br_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_reg <= 16'h0000;
        end else if (start_load) begin
            br_cnt_reg <= 16'h0000;
        end else if (take_evt && (br_cnt_reg != 16'hFFFF)) begin
            br_cnt_reg <= br_cnt_reg + 16'h0001;
        end
    end

    assign bus.br_cnt = br_cnt_reg;
`else
    logic unused_stats;
    assign unused_stats = start_load ^ take_evt;
`endif
endmodule
